regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised integer register file for the RISC-V core, with two read ports and two write ports. Write port 0 serves the ALU/writeback stage; write port 1 serves late (load) results. It adds an optional same-cycle write-to-read bypass and a per-register pending scoreboard that decode uses to detect load-use hazards. It replaces the fixed 32x32 single-write-port register file.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >= 2)
AW, $clog2(NREG), register index width (derived, not to be overridden)
BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous active-high reset
rs1  input  AW  read port 1 index
rs2  input  AW  read port 2 index
read_data1  output  XLEN  read port 1 data (combinational)
read_data2  output  XLEN  read port 2 data (combinational)
rd0  input  AW  write port 0 index
we0  input  1  write port 0 enable
wdata0  input  XLEN  write port 0 data
rd1  input  AW  write port 1 index (load return)
we1  input  1  write port 1 enable; also clears pending[rd1]
wdata1  input  XLEN  write port 1 data
alloc_en  input  1  mark alloc_rd pending (load issued)
alloc_rd  input  AW  register to mark pending
busy1  output  1  rs1 has an outstanding load result
busy2  output  1  rs2 has an outstanding load result

Behaviour:
- Reset asserted (asynchronous, any time, including mid-write): all registers = 0 and all pending bits = 0 immediately. read_data1/2 then reflect 0 (or bypass data per the rules below). busy1/2 = 0. Writes and allocs are ignored while reset is high.
- Register 0: always reads 0, including under bypass. Writes and allocs to index 0 are discarded. pending[0] is never set.
- Writes: committed on posedge clk when weN=1 and rdN!=0.
- Write-write collision (we0 & we1 & rd0==rd1): port 0 data is stored. Port 1 still clears pending.
- Reads are combinational from array. With BYPASS=1, if a read index matches an active write this cycle (nonzero index), the output returns that write data, using the same priority (port 0 over port 1). With BYPASS=0, the new value is visible only after the edge.
- Scoreboard: pending[alloc_rd] is set at posedge when alloc_en=1. pending[rd1] is cleared at posedge when we1=1. Port 0 writes never touch pending.
- Same-edge alloc and clear of the same register: set wins (a new load overrides the returning one).
- Alloc to an already-pending register: it stays pending. No counting; a single clear releases it.
- busyN = pending[rsN] & (rsN!=0).
- With BYPASS=1, busyN is additionally forced 0 when we1=1 & rd1==rsN, because the data is forwarded that cycle.
- With BYPASS=0, busyN stays 1 until the edge after the clear.
- No other latency: reads are 0-cycle, writes and scoreboard updates are 1-cycle.
- Parameter rules: NREG not a power of two is unsupported. XLEN is arbitrary >= 1.

Test Plan:
- Reset mid-write: write x5=AAAA5555 and commit; assert reset asynchronously between edges -> read_data1 for x5 = 00000000 before the next edge; busy1 = 0.
- Basic write/read (BYPASS=1): write x5=AAAA5555, x10=12345678, x15=DEADBEEF, then read (5,10) and (15,0) -> AAAA5555/12345678 and DEADBEEF/00000000.
- x0 hardwired: we0 with rd0=0, wdata0=FFFFFFFF, plus alloc_rd=0 -> read x0 = 00000000 during the write cycle and after it; busy = 0.
- Bypass vs none: rs1=7; in the same cycle we0 to x7 = 11112222 -> BYPASS=1 gives read_data1 = 11112222 before the edge. BYPASS=0 gives the old value before the edge and 11112222 after it.
- Collision: we0 x3=000000AA and we1 x3=000000BB on the same edge, with x3 pending -> x3 = 000000AA and pending[3] cleared.
- Scoreboard:
  - alloc x9, rs2=9 -> busy2=1 next cycle.
  - we1 x9=CAFEF00D -> busy2=0 and read_data2=CAFEF00D in the same cycle (BYPASS=1).
  - alloc x9 and we1 x9 on the same edge -> busy2 stays 1 afterwards.

Source files
------------

// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with two read ports, two write ports
// (port 0 = ALU/writeback, port 1 = load return), optional same-cycle
// write-to-read bypass and a per-register load-pending scoreboard.
module regfile_sb #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int AW     = $clog2(NREG),
   parameter int BYPASS = 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [AW-1:0]   rs1,
   input  logic [AW-1:0]   rs2,
   output logic [XLEN-1:0] read_data1,
   output logic [XLEN-1:0] read_data2,
   input  logic [AW-1:0]   rd0,
   input  logic            we0,
   input  logic [XLEN-1:0] wdata0,
   input  logic [AW-1:0]   rd1,
   input  logic            we1,
   input  logic [XLEN-1:0] wdata1,
   input  logic            alloc_en,
   input  logic [AW-1:0]   alloc_rd,
   output logic            busy1,
   output logic            busy2
);

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   logic [NREG-1:0] pend_q;
   logic [NREG-1:0] pend_d;

   // Writes to x0 are dropped here, so regs_q[0] never leaves zero.
   logic wr0_ok;
   logic wr1_ok;
   assign wr0_ok = we0 && (rd0 != '0);
   assign wr1_ok = we1 && (rd1 != '0);

   // Next register state: port 1 first so port 0 overwrites it on a collision.
   always_comb begin
      regs_d = regs_q;
      if (wr1_ok) regs_d[rd1] = wdata1;
      if (wr0_ok) regs_d[rd0] = wdata0;
   end

   // Next scoreboard state: a load return clears, a new alloc sets and wins.
   always_comb begin
      pend_d = pend_q;
      if (we1) pend_d[rd1] = 1'b0;
      if (alloc_en && (alloc_rd != '0)) pend_d[alloc_rd] = 1'b1;
   end

   // State registers; reset clears every register and pending bit at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
         pend_q <= '0;
      end else begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
         pend_q <= pend_d;
      end
   end

   // Both read ports share one structure, indexed by port number.
   logic [1:0][AW-1:0]   rs_v;
   logic [1:0][XLEN-1:0] rdata_v;
   logic [1:0]           busy_v;
   assign rs_v = {rs2, rs1};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_rd
         logic hit0;
         logic hit1;
         // A hit requires a nonzero write index, so x0 always reads 0.
         assign hit0 = (BYPASS != 0) && wr0_ok && (rd0 == rs_v[gi]);
         assign hit1 = (BYPASS != 0) && wr1_ok && (rd1 == rs_v[gi]);
         assign rdata_v[gi] = hit0 ? wdata0 :
                              hit1 ? wdata1 : regs_q[rs_v[gi]];
         // A returning load is forwarded this cycle, so it no longer stalls.
         assign busy_v[gi] = pend_q[rs_v[gi]] && (rs_v[gi] != '0) && !hit1;
      end
   endgenerate

   assign read_data1 = rdata_v[0];
   assign read_data2 = rdata_v[1];
   assign busy1      = busy_v[0];
   assign busy2      = busy_v[1];

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: table-driven check of regfile_sb, one instance with bypass
// and one without, both fed the same stimulus.
module tb_regfile_sb;

   logic        clk = 1'b0;
   logic        reset;
   logic [4:0]  rs1, rs2, rd0, rd1, alloc_rd;
   logic        we0, we1, alloc_en;
   logic [31:0] wdata0, wdata1;
   logic [31:0] rdat1, rdat2, nrdat1, nrdat2;
   logic        bsy1, bsy2, nbsy1, nbsy2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(1)) dut (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
      .read_data1(rdat1), .read_data2(rdat2),
      .rd0(rd0), .we0(we0), .wdata0(wdata0),
      .rd1(rd1), .we1(we1), .wdata1(wdata1),
      .alloc_en(alloc_en), .alloc_rd(alloc_rd),
      .busy1(bsy1), .busy2(bsy2)
   );

   regfile_sb #(.XLEN(32), .NREG(32), .BYPASS(0)) dut_nb (
      .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2),
      .read_data1(nrdat1), .read_data2(nrdat2),
      .rd0(rd0), .we0(we0), .wdata0(wdata0),
      .rd1(rd1), .we1(we1), .wdata1(wdata1),
      .alloc_en(alloc_en), .alloc_rd(alloc_rd),
      .busy1(nbsy1), .busy2(nbsy2)
   );

   typedef struct {
      logic        we0;  logic [4:0] rd0;  logic [31:0] wd0;
      logic        we1;  logic [4:0] rd1;  logic [31:0] wd1;
      logic        al;   logic [4:0] ard;
      logic [4:0]  rs1;  logic [4:0] rs2;
      logic [31:0] e1;   logic [31:0] e2;  logic eb1; logic eb2;
      logic [31:0] n1;   logic nb1;
      string       name;
   } vec_t;

   vec_t vecs [23];
   vec_t sb_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic idle_inputs();
      we0 = 0; rd0 = 0; wdata0 = 0;
      we1 = 0; rd1 = 0; wdata1 = 0;
      alloc_en = 0; alloc_rd = 0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // pre-edge expectations: {we0,rd0,wd0, we1,rd1,wd1, al,ard, rs1,rs2,
      //  e1,e2,eb1,eb2 (bypass), n1,nb1 (no bypass), name}
      vecs[0]  = '{1,5,32'hAAAA5555, 0,0,0, 0,0, 5,10, 32'hAAAA5555,0,0,0, 0,0, "wr_x5"};
      vecs[1]  = '{1,10,32'h12345678, 0,0,0, 0,0, 5,10, 32'hAAAA5555,32'h12345678,0,0, 32'hAAAA5555,0, "wr_x10"};
      vecs[2]  = '{0,0,0, 1,15,32'hDEADBEEF, 0,0, 15,0, 32'hDEADBEEF,0,0,0, 0,0, "wr_x15_p1"};
      vecs[3]  = '{0,0,0, 0,0,0, 0,0, 5,10, 32'hAAAA5555,32'h12345678,0,0, 32'hAAAA5555,0, "rd_5_10"};
      vecs[4]  = '{0,0,0, 0,0,0, 0,0, 15,0, 32'hDEADBEEF,0,0,0, 32'hDEADBEEF,0, "rd_15_0"};
      vecs[5]  = '{1,0,32'hFFFFFFFF, 0,0,0, 1,0, 0,0, 0,0,0,0, 0,0, "x0_write"};
      vecs[6]  = '{0,0,0, 0,0,0, 0,0, 0,0, 0,0,0,0, 0,0, "x0_after"};
      vecs[7]  = '{1,7,32'h11112222, 0,0,0, 0,0, 7,5, 32'h11112222,32'hAAAA5555,0,0, 0,0, "bypass_x7"};
      vecs[8]  = '{0,0,0, 0,0,0, 0,0, 7,5, 32'h11112222,32'hAAAA5555,0,0, 32'h11112222,0, "after_x7"};
      vecs[9]  = '{0,0,0, 0,0,0, 1,3, 3,3, 0,0,0,0, 0,0, "alloc_x3"};
      vecs[10] = '{1,3,32'h000000AA, 1,3,32'h000000BB, 0,0, 3,0, 32'h000000AA,0,0,0, 0,1, "collide_x3"};
      vecs[11] = '{0,0,0, 0,0,0, 0,0, 3,3, 32'h000000AA,32'h000000AA,0,0, 32'h000000AA,0, "after_collide"};
      vecs[12] = '{0,0,0, 0,0,0, 1,9, 9,9, 0,0,0,0, 0,0, "alloc_x9"};
      vecs[13] = '{0,0,0, 0,0,0, 0,0, 9,9, 0,0,1,1, 0,1, "busy_x9"};
      vecs[14] = '{0,0,0, 1,9,32'hCAFEF00D, 0,0, 9,9, 32'hCAFEF00D,32'hCAFEF00D,0,0, 0,1, "load_ret_x9"};
      vecs[15] = '{0,0,0, 0,0,0, 0,0, 9,9, 32'hCAFEF00D,32'hCAFEF00D,0,0, 32'hCAFEF00D,0, "after_ret_x9"};
      vecs[16] = '{0,0,0, 0,0,0, 1,9, 9,9, 32'hCAFEF00D,32'hCAFEF00D,0,0, 32'hCAFEF00D,0, "alloc_x9_b"};
      vecs[17] = '{0,0,0, 1,9,32'h12121212, 1,9, 9,9, 32'h12121212,32'h12121212,0,0, 32'hCAFEF00D,1, "alloc_and_ret"};
      vecs[18] = '{0,0,0, 0,0,0, 0,0, 9,9, 32'h12121212,32'h12121212,1,1, 32'h12121212,1, "set_wins"};
      vecs[19] = '{0,0,0, 0,0,0, 1,9, 9,9, 32'h12121212,32'h12121212,1,1, 32'h12121212,1, "realloc_x9"};
      vecs[20] = '{0,0,0, 0,0,0, 0,0, 9,9, 32'h12121212,32'h12121212,1,1, 32'h12121212,1, "still_pending"};
      vecs[21] = '{0,0,0, 1,9,32'h34343434, 0,0, 9,9, 32'h34343434,32'h34343434,0,0, 32'h12121212,1, "single_clear"};
      vecs[22] = '{0,0,0, 0,0,0, 0,0, 9,9, 32'h34343434,32'h34343434,0,0, 32'h34343434,0, "released"};

      // Reset state
      reset = 1'b1;
      idle_inputs();
      rs1 = 5; rs2 = 9;
      @(posedge clk); #1;
      chk("reset_rd1", rdat1, 32'h0);
      chk("reset_rd2", rdat2, 32'h0);
      chk("reset_busy1", {31'b0, bsy1}, 32'h0);
      chk("reset_busy2", {31'b0, bsy2}, 32'h0);
      reset = 1'b0;

      // Table: drive at posedge+1, push expectation, compare at negedge
      for (int i = 0; i < 23; i++) begin
         we0 = vecs[i].we0; rd0 = vecs[i].rd0; wdata0 = vecs[i].wd0;
         we1 = vecs[i].we1; rd1 = vecs[i].rd1; wdata1 = vecs[i].wd1;
         alloc_en = vecs[i].al; alloc_rd = vecs[i].ard;
         rs1 = vecs[i].rs1; rs2 = vecs[i].rs2;
         sb_q.push_back(vecs[i]);
         @(negedge clk);
         begin
            vec_t e;
            e = sb_q.pop_front();
            chk({e.name, ".rd1"},  rdat1, e.e1);
            chk({e.name, ".rd2"},  rdat2, e.e2);
            chk({e.name, ".busy1"}, {31'b0, bsy1}, {31'b0, e.eb1});
            chk({e.name, ".busy2"}, {31'b0, bsy2}, {31'b0, e.eb2});
            chk({e.name, ".nb_rd1"}, nrdat1, e.n1);
            chk({e.name, ".nb_busy1"}, {31'b0, nbsy1}, {31'b0, e.nb1});
            $display("[TB] vec %0d %s rd1=%h rd2=%h busy=%b%b nb_rd1=%h nb_busy1=%b",
                     i, e.name, rdat1, rdat2, bsy1, bsy2, nrdat1, nbsy1);
         end
         @(posedge clk); #1;
      end
      chk("scoreboard_drained", sb_q.size(), 32'h0);

      // Reset mid-write: x5 holds AAAA5555 and is pending, then reset between edges
      idle_inputs();
      alloc_en = 1; alloc_rd = 5;
      @(posedge clk); #1;
      idle_inputs();
      we0 = 1; rd0 = 20; wdata0 = 32'h0F0F0F0F;
      rs1 = 5; rs2 = 20;
      #1;
      chk("pre_reset_rd1", rdat1, 32'hAAAA5555);
      chk("pre_reset_busy1", {31'b0, bsy1}, 32'h1);
      reset = 1'b1;
      #1;
      chk("mid_reset_rd1", rdat1, 32'h0);
      chk("mid_reset_busy1", {31'b0, bsy1}, 32'h0);
      chk("mid_reset_nb_rd2", nrdat2, 32'h0);
      $display("[TB] mid-write reset rd1=%h busy1=%b nb_rd2=%h", rdat1, bsy1, nrdat2);
      // An edge with reset still high must not commit the write
      @(posedge clk); #1;
      idle_inputs();
      #1;
      chk("reset_blocks_write", rdat2, 32'h0);
      chk("reset_blocks_write_nb", nrdat2, 32'h0);
      reset = 1'b0;
      rs1 = 10; rs2 = 15;
      @(negedge clk);
      chk("post_reset_x10", rdat1, 32'h0);
      chk("post_reset_x15", rdat2, 32'h0);
      $display("[TB] after reset x10=%h x15=%h", rdat1, rdat2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
